// File: rtl/apb_arb_pkg.sv
// apb_arb_pkg: shared state encoding, default widths and helpers for the APB bus arbiter.
package apb_arb_pkg;

    // Plain logic constants keep the encoding visible to legacy tools and waveform viewers.
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_SETUP  = 2'd1;
    localparam state_t ST_ACCESS = 2'd2;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int NUM_REQ_MAX = 8;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; the first set request at or after ptr_i wins.
module rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int IDX_W  = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               gnt_valid_o
);

    int cand;

    // NOTE: every signal driven here gets a default before the loop, so no latch is inferred.
    always_comb begin
        gnt_o       = '0;
        gnt_idx_o   = '0;
        gnt_valid_o = 1'b0;
        cand        = 0;
        // Walk from the farthest offset down so the nearest match is the one left standing.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = int'(ptr_i) + off;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (req_i[cand[IDX_W-1:0]]) begin
                gnt_o       = NUM_REQ'(1) << cand[IDX_W-1:0];
                gnt_idx_o   = cand[IDX_W-1:0];
                gnt_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_bus_arbiter.sv
// apb_bus_arbiter: round-robin APB master sharing one APB bus among NUM_REQ requesters.
// The ACCESS-phase timeout is compiled in only when APB_ARB_TIMEOUT_EN is defined.
module apb_bus_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    output logic                      pselx,
    output logic                      penable,
    input  logic                      pready,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pslverr
);

    localparam int IDX_W = idx_w(NUM_REQ);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   gnt_idx_q, gnt_idx_d;
    logic [ADDR_W-1:0]  paddr_q, paddr_d;
    logic               pwrite_q, pwrite_d;
    logic [DATA_W-1:0]  pwdata_q, pwdata_d;
    logic               pselx_q, pselx_d;
    logic               penable_q, penable_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic               grant_en;
    logic               timeout_hit;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i       (req_valid),
        .ptr_i       (rr_ptr_q),
        .gnt_o       (arb_gnt),
        .gnt_idx_o   (arb_idx),
        .gnt_valid_o (arb_valid)
    );

    // No grant in the cycle carrying a response: keeps an IDLE gap and caps throughput at 1 per 4.
    assign grant_en  = (state_q == ST_IDLE) && (rsp_valid_q == '0) && arb_valid;
    assign req_ready = (grant_en && !presetn) ? arb_gnt : '0;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int CNT_W = idx_w(TIMEOUT_CYCLES) + 1;

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_SETUP) begin
            tmo_cnt_d = '0;
        end else if ((state_q == ST_ACCESS) && !pready) begin
            tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_hit = (state_q == ST_ACCESS) && !pready &&
                         (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_idx_d   = gnt_idx_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pselx_d     = pselx_q;
        penable_d   = penable_q;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_en) begin
                    gnt_idx_d = arb_idx;
                    paddr_d   = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
                    pwdata_d  = req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
                    pwrite_d  = req_write[arb_idx];
                    pselx_d   = 1'b1;
                    state_d   = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready || timeout_hit) begin
                    state_d     = ST_IDLE;
                    pselx_d     = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = NUM_REQ'(1) << gnt_idx_q;
                    rsp_err_d   = pready ? pslverr : 1'b1;
                    rsp_rdata_d = (pready && !pwrite_q) ? prdata : '0;
                    rr_ptr_d    = (gnt_idx_q == IDX_W'(NUM_REQ - 1)) ? '0
                                                                    : gnt_idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments only; all next-state math lives in always_comb.
    always_ff @(posedge pclk or posedge presetn) begin
        if (presetn) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            gnt_idx_q   <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pselx_q     <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_idx_q   <= gnt_idx_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pselx_q     <= pselx_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign pselx     = pselx_q;
    assign penable   = penable_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// tb_apb_bus_arbiter: directed and randomized checks of apb_bus_arbiter against a transaction-level model.
module tb_apb_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TC = 16;

    logic            pclk    = 1'b0;
    logic            presetn = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic [AW-1:0]   paddr;
    logic            pwrite;
    logic [DW-1:0]   pwdata;
    logic            pselx;
    logic            penable;
    logic            pready  = 1'b0;
    logic [DW-1:0]   prdata  = '0;
    logic            pslverr = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    apb_bus_arbiter #(
        .NUM_REQ        (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TC)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .paddr     (paddr),
        .pwrite    (pwrite),
        .pwdata    (pwdata),
        .pselx     (pselx),
        .penable   (penable),
        .pready    (pready),
        .prdata    (prdata),
        .pslverr   (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- slave: pready after a configurable number of low ACCESS cycles
    bit            slv_rand  = 1'b0;
    int            slv_wait  = 0;
    logic [DW-1:0] slv_rdata = '0;
    logic          slv_err   = 1'b0;
    int            acc_n     = 0;
    int            cur_wait  = 0;

    always @(posedge pclk) begin
        #1;
        if (pselx && penable) begin
            acc_n++;
        end else begin
            acc_n    = 0;
            cur_wait = slv_rand ? int'($urandom_range(0, 3)) : slv_wait;
        end
        if (pselx && penable && acc_n > cur_wait) begin
            pready  = 1'b1;
            prdata  = slv_rand ? DW'($urandom) : slv_rdata;
            pslverr = slv_rand ? ($urandom_range(0, 3) == 0) : slv_err;
        end else begin
            pready  = 1'b0;
            prdata  = DW'($urandom);
            pslverr = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- transaction-level model: one transfer in flight, age counted from acceptance
    bit            m_active = 1'b0;
    bit            m_pend   = 1'b0;
    bit            m_write  = 1'b0;
    bit            m_rsp_err = 1'b0;
    int            m_req = 0, m_age = 0, m_ptr = 0, m_rsp_req = 0;
    logic [AW-1:0] m_paddr     = '0;
    logic [DW-1:0] m_pwdata    = '0;
    logic [DW-1:0] m_rsp_rdata = '0;

    function automatic int pick(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge pclk) begin
        if (presetn) begin
            m_active = 1'b0; m_pend = 1'b0; m_write = 1'b0; m_rsp_err = 1'b0;
            m_ptr = 0; m_age = 0; m_req = 0; m_rsp_req = 0;
            m_paddr = '0; m_pwdata = '0; m_rsp_rdata = '0;
        end else begin
            bit fin;
            int g;
            fin = 1'b0;
            g   = -1;
            if (m_active) begin
                if (m_age >= 1) begin
                    if (pready) begin
                        fin = 1'b1; m_rsp_err = pslverr;
                        m_rsp_rdata = m_write ? '0 : prdata;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else if (m_age - 1 == TC - 1) begin
                        fin = 1'b1; m_rsp_err = 1'b1; m_rsp_rdata = '0;
                    end
`endif
                end
                if (fin) begin
                    m_active = 1'b0; m_rsp_req = m_req; m_ptr = (m_req + 1) % N;
                end else begin
                    m_age++;
                end
            end else if (!m_pend) begin
                g = pick(m_ptr, req_valid);
                if (g >= 0) begin
                    m_active = 1'b1; m_age = 0; m_req = g;
                    m_paddr  = req_addr[g*AW +: AW];
                    m_pwdata = req_wdata[g*DW +: DW];
                    m_write  = req_write[g];
                end
            end
            m_pend = fin;
        end
    end

    task automatic compare();
        logic [N-1:0] exp_ready, exp_rv;
        int g;
        exp_ready = '0;
        exp_rv    = '0;
        if (!presetn) begin
            if (!m_active && !m_pend) begin
                g = pick(m_ptr, req_valid);
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            if (m_pend) exp_rv[m_rsp_req] = 1'b1;
        end
        check("req_ready", 64'(req_ready), 64'(exp_ready));
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        check("pselx",     64'(pselx),   64'(!presetn && m_active));
        check("penable",   64'(penable), 64'(!presetn && m_active && m_age >= 1));
        check("paddr",     64'(paddr),   presetn ? 64'd0 : 64'(m_paddr));
        check("pwdata",    64'(pwdata),  presetn ? 64'd0 : 64'(m_pwdata));
        check("pwrite",    64'(pwrite),  64'(!presetn && m_write));
        if (exp_rv != '0) begin
            check("rsp_rdata", 64'(rsp_rdata), 64'(m_rsp_rdata));
            check("rsp_err",   64'(rsp_err),   64'(m_rsp_err));
        end
    endtask

    // ---------------- stimulus helpers
    task automatic cyc();
        @(posedge pclk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge pclk);
        #2 presetn = 1'b1;
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b0;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]        = wr;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
        req_valid[i]        = 1'b1;
    endtask

    task automatic wait_grant(input int budget, output int g);
        g = -1;
        for (int c = 0; c < budget && g < 0; c++) begin
            @(negedge pclk);
            for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
        end
        if (g < 0) begin
            n_checks++; n_err++;
            $display("FAIL wait_grant: no req_ready within %0d cycles", budget);
        end
    endtask

    task automatic drive_random(input logic [N-1:0] seen, input bit allow_new);
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && seen[i]) begin
                req_valid[i] = 1'b0;
            end else if (req_valid[i]) begin
                if (allow_new && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
            end else if (allow_new && $urandom_range(0, 3) == 0) begin
                set_req(i, 1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [N-1:0] seen;
    int           g, cnt;
    bit           got;
    int           exp_order [4] = '{0, 1, 0, 1};

    initial begin
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        fork
            forever begin
                @(negedge pclk);
                compare();
            end
        join_none

        // reset state
        @(negedge pclk);
        check("reset_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("reset_rsp_err",   64'(rsp_err),   64'd0);
        cyc();
        presetn = 1'b0;

        // single zero-wait read from requester 0
        slv_wait = 0; slv_rdata = 32'hDEAD_BEEF; slv_err = 1'b0;
        set_req(0, 1'b0, 32'h0000_0010, 32'h0);
        @(negedge pclk);
        check("t1_ready", 64'(req_ready), 64'h1);
        cyc();
        req_valid[0] = 1'b0;
        @(negedge pclk);
        check("t1_setup_psel", 64'({pselx, penable}), 64'b10);
        check("t1_paddr",      64'(paddr), 64'h10);
        @(negedge pclk);
        check("t1_access_psel", 64'({pselx, penable}), 64'b11);
        @(negedge pclk);
        check("t1_rsp_valid", 64'(rsp_valid), 64'h1);
        check("t1_rsp_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
        check("t1_rsp_err",   64'(rsp_err),   64'h0);
        check("t1_psel_off",  64'(pselx),     64'h0);

        // contention after reset: 0,1,0,1
        do_reset();
        set_req(0, 1'b0, 32'h100, 32'h0);
        set_req(1, 1'b1, 32'h104, 32'h55);
        for (int k = 0; k < 4; k++) begin
            wait_grant(20, g);
            check("t2_grant_order", 64'(g), 64'(exp_order[k]));
        end
        cyc();
        req_valid = '0;
        repeat (5) @(negedge pclk);

        // wait states plus slave error on a write
        slv_wait = 5; slv_err = 1'b1;
        set_req(2, 1'b1, 32'h44, 32'h1234_5678);
        wait_grant(10, g);
        check("t3_grant", 64'(g), 64'd2);
        cyc();
        req_valid[2] = 1'b0;
        cnt = 0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge pclk);
            if (rsp_valid != '0) got = 1'b1;
            else if (pselx && pwrite && paddr == 32'h44 && pwdata == 32'h1234_5678) cnt++;
        end
        check("t3_stable_cycles", 64'(cnt),       64'd7);
        check("t3_rsp_valid",     64'(rsp_valid), 64'h4);
        check("t3_rsp_err",       64'(rsp_err),   64'h1);
        check("t3_rsp_rdata",     64'(rsp_rdata), 64'h0);
        slv_err = 1'b0;

`ifdef APB_ARB_TIMEOUT_EN
        // stuck slave: timeout after TC ACCESS cycles, then a normal transfer
        slv_wait = 1000;
        set_req(1, 1'b0, 32'h80, 32'h0);
        wait_grant(10, g);
        cyc();
        req_valid[1] = 1'b0;
        cnt = 0; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge pclk);
            if (rsp_valid != '0) got = 1'b1;
            else if (penable) cnt++;
        end
        check("t4_access_cycles", 64'(cnt),       64'd16);
        check("t4_rsp_valid",     64'(rsp_valid), 64'h2);
        check("t4_rsp_err",       64'(rsp_err),   64'h1);
        check("t4_rsp_rdata",     64'(rsp_rdata), 64'h0);
        slv_wait = 0; slv_rdata = 32'hCAFE_0001;
        set_req(0, 1'b0, 32'h84, 32'h0);
        wait_grant(10, g);
        cyc();
        req_valid[0] = 1'b0;
        repeat (2) @(negedge pclk);
        check("t4_next_rsp_valid", 64'(rsp_valid), 64'h1);
        check("t4_next_rsp_err",   64'(rsp_err),   64'h0);
        check("t4_next_rsp_rdata", 64'(rsp_rdata), 64'hCAFE_0001);
`endif

        // reset in the middle of ACCESS
        slv_wait = 3;
        set_req(3, 1'b0, 32'h90, 32'h0);
        wait_grant(10, g);
        cyc();
        req_valid[3] = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge pclk);
            if (penable) got = 1'b1;
        end
        check("t5_in_access", 64'(penable), 64'h1);
        #2 presetn = 1'b1;
        set_req(0, 1'b0, 32'hA0, 32'h0); set_req(1, 1'b0, 32'hA4, 32'h0);
        set_req(2, 1'b0, 32'hA8, 32'h0); set_req(3, 1'b0, 32'hAC, 32'h0);
        #1;
        check("t5_async_psel",  64'({pselx, penable}),    64'b00);
        check("t5_async_hshk",  64'({req_ready, rsp_valid}), 64'h0);
        repeat (2) @(posedge pclk);
        #1 presetn = 1'b0;
        wait_grant(5, g);
        check("t5_first_grant", 64'(g), 64'd0);
        cyc();
        req_valid = '0;

        // rr_ptr=2 with requesters 1 and 3 pending: 3 first, then wrap to 1
        slv_wait = 0;
        set_req(1, 1'b1, 32'hB0, 32'h11);
        wait_grant(10, g);
        check("t6_setup_grant", 64'(g), 64'd1);
        cyc();
        req_valid[1] = 1'b0;
        repeat (4) @(negedge pclk);
        cyc();
        set_req(1, 1'b0, 32'hB4, 32'h0);
        set_req(3, 1'b0, 32'hBC, 32'h0);
        wait_grant(10, g);
        check("t6_grant_a", 64'(g), 64'd3);
        cyc();
        req_valid[3] = 1'b0;
        wait_grant(10, g);
        check("t6_grant_b", 64'(g), 64'd1);
        cyc();
        req_valid = '0;
        repeat (4) @(negedge pclk);

        // randomized traffic and slave behaviour, then drain
        slv_rand = 1'b1;
        for (int it = 0; it < 3060; it++) begin
            @(negedge pclk);
            seen = req_ready;
            @(posedge pclk);
            #1;
            drive_random(seen, it < 3000);
        end
        check("drain_all_granted", 64'(req_valid), 64'h0);
        repeat (8) @(negedge pclk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/apb_bus_arbiter.md
# apb_bus_arbiter

Round-robin APB master that shares one APB bus among NUM_REQ local requesters. It accepts one request at a time, runs the APB SETUP/ACCESS sequence on the `apb_intf` signal set (paddr, pselx, penable, pwrite, pwdata, pready, prdata, pslverr), and returns read data and error status to the granted requester. It sits between the register-access sources (for example RAL frontdoor and debug port) and the single APB slave fabric.

## Interface
- NUM_REQ, 2 — number of requesters; legal range is 2 to 8.
- ADDR_W, 32 — APB address width.
- DATA_W, 32 — APB data width.
- TIMEOUT_CYCLES, 16 — maximum ACCESS-phase cycles. Used only when the timeout feature is compiled in.
- pclk  in  1  single clock; all logic is on the rising edge.
- presetn  in  1  asynchronous, active-high reset. The port keeps its codebase name; the polarity is high.
- req_valid  in  NUM_REQ  per-requester transfer request.
- req_write  in  NUM_REQ  1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data, laid out the same way.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data, shared by all requesters. Valid while rsp_valid is nonzero.
- rsp_err  out  1  transfer error. Valid with rsp_valid.
- paddr, pwrite, pwdata  out  ADDR_W/1/DATA_W  APB request fields, registered.
- pselx, penable  out  1  APB phase controls, registered.
- pready, prdata, pslverr  in  1/DATA_W/1  APB slave response.

## Operation
- The FSM has three states: IDLE, SETUP and ACCESS.
- **IDLE**
  - If any req_valid is set, grant g is the first set bit found by searching circularly from rr_ptr.
  - The arbiter latches req_addr[g], req_write[g] and req_wdata[g] into paddr, pwrite and pwdata.
  - It pulses req_ready[g] and moves to SETUP.
  - If no req_valid is set, it stays in IDLE.
- **SETUP**: pselx=1, penable=0. Always moves to ACCESS on the next cycle.
- **ACCESS**
  - Holds pselx=1, penable=1.
  - The arbiter samples pready on every edge. When pready=1, it registers prdata into rsp_rdata and pslverr into rsp_err, pulses rsp_valid[g], sets rr_ptr = (g+1) mod NUM_REQ, and returns to IDLE.
- rsp_rdata is forced to 0 for writes.
- paddr, pwrite and pwdata remain stable from SETUP through the completing ACCESS cycle.
- In IDLE, pselx=0 and penable=0. paddr and pwdata hold their last values.
- The arbiter has no back-to-back shortcut. At least one IDLE cycle separates any two transfers.
- A requester must hold its req_* signals until it sees req_ready. A requester may drop req_valid before it is granted.
- Requests raised during SETUP or ACCESS wait in IDLE arbitration.

## Timing
- **Reset values**: all outputs are 0, the state is IDLE, rr_ptr=0 and the grant register is 0.
- **Reset mid-transfer**: pselx and penable drop asynchronously. No rsp_valid is issued for the aborted transfer.
- **Cycle numbering for a transfer**:
  - Cycle 0 (IDLE): req_ready pulses.
  - Cycle 1: SETUP.
  - Cycle 2 onward: ACCESS.
  - rsp_valid is asserted in the cycle after the edge that samples pready=1.
- **Latency**: with zero wait states, rsp_valid is high 3 cycles after the req_ready cycle.
- **Throughput**: one transfer per 4 cycles at most.
- **Simultaneous requests**: the requester nearest rr_ptr in circular order wins. No requester waits longer than NUM_REQ−1 transfers.
- **Pointer wrap**: when g = NUM_REQ−1, rr_ptr becomes 0.

## Configuration
- **APB_ARB_TIMEOUT_EN defined**
  - A counter starts at 0 on entry to ACCESS and increments on each cycle without pready.
  - When the counter reaches TIMEOUT_CYCLES−1 and pready is still 0, the transfer completes with rsp_err=1 and rsp_rdata=0. The FSM returns to IDLE and rr_ptr advances.
  - pready=1 in the same cycle as the limit counts as a normal completion.
- **APB_ARB_TIMEOUT_EN undefined**: there is no counter, ACCESS waits indefinitely for pready, and TIMEOUT_CYCLES is ignored.

## Structure
- Package apb_arb_pkg holds:
  - the state typedef (IDLE, SETUP, ACCESS);
  - ADDR_W and DATA_W default localparams;
  - a NUM_REQ maximum constant of 8.
- Sub-module rr_arbiter takes req and ptr and produces a one-hot grant plus the grant index. It is purely combinational and parameterised on NUM_REQ.
- The FSM, datapath registers and timeout counter live in the top module.

## Test plan
- Single read, zero wait states: requester 0 reads 0x0000_0010 with prdata=0xDEAD_BEEF → pselx high for 2 cycles; rsp_valid=2'b01, rsp_rdata=0xDEAD_BEEF and rsp_err=0 three cycles after req_ready.
- Contention after reset: both requesters valid after reset → grant order 0,1,0,1 over 4 transfers. Each rsp_valid matches its earlier req_ready.
- Wait states and error: pready held low for 5 ACCESS cycles, then pready=1 with pslverr=1 on a write → paddr and pwdata stable for 7 cycles; rsp_err=1 and rsp_rdata=0.
- Timeout (macro defined, TIMEOUT_CYCLES=16): pready stuck at 0 → completion after 16 ACCESS cycles with rsp_err=1. The next transfer proceeds normally.
- Reset mid-ACCESS: assert presetn during a transfer → pselx, penable and req_ready/rsp_valid are 0 immediately. After release, the first grant goes to requester 0.
- NUM_REQ=4, requesters 1 and 3 valid with rr_ptr=2 → requester 3 is granted first, then requester 1, and rr_ptr wraps through 0.
